// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory read port and decode handshake of the fetch stage
interface instruction_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              run;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_rd;
  logic              mem_wn;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_read_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  modport master (
    input  run, redirect_valid, redirect_pc, mem_read_data, instr_ready,
    output mem_rd, mem_wn, mem_address, instr_valid, instr, instr_pc
  );
  modport slave (
    output run, redirect_valid, redirect_pc, mem_read_data, instr_ready,
    input  mem_rd, mem_wn, mem_address, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing one-cycle-latency word reads into a 2-entry instruction buffer
module instruction_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset_n,
  instruction_fetch_if.master bus
);
  logic [ADDR_W-1:0]      pc_q, pc_d, pend_pc_q;
  logic                   pend_q;
  logic [1:0]             occ_q, occ_d;
  logic [1:0][DATA_W-1:0] dat_q, dat_d;
  logic [1:0][ADDR_W-1:0] tag_q, tag_d;
  logic                   redir, pop, push, issue, wp;
  logic [2:0]             cnt;
  always_comb begin
    redir = bus.redirect_valid;
    pop   = (occ_q != 2'd0) & bus.instr_ready & ~redir;
    push  = pend_q & ~redir;
    cnt   = 3'(occ_q) + 3'(pend_q) - 3'(pop);
    // buffered plus in-flight never exceeds two, so a push always finds a free slot
    issue = reset_n & bus.run & ~redir & (cnt < 3'd2);
    pc_d  = redir ? bus.redirect_pc : issue ? pc_q + ADDR_W'(1) : pc_q;
    occ_d = redir ? 2'd0 : occ_q + 2'(push) - 2'(pop);
    wp    = occ_q[0] ^ pop;
    dat_d = dat_q;
    tag_d = tag_q;
    if (pop) begin
      dat_d[0] = dat_q[1];
      tag_d[0] = tag_q[1];
    end
    if (push) begin
      dat_d[wp] = bus.mem_read_data;
      tag_d[wp] = pend_pc_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      occ_q     <= 2'd0;
      dat_q     <= '0;
      tag_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= issue;
      pend_pc_q <= pc_q;
      occ_q     <= occ_d;
      dat_q     <= dat_d;
      tag_q     <= tag_d;
    end
  end
  assign bus.mem_rd      = issue;
  assign bus.mem_wn      = 1'b0;
  assign bus.mem_address = pc_q;
  assign bus.instr_valid = occ_q != 2'd0;
  assign bus.instr       = bus.instr_valid ? dat_q[0] : '0;
  assign bus.instr_pc    = bus.instr_valid ? tag_q[0] : '0;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly upstream of the instruction memory. It owns the program counter, issues word reads to the memory's synchronous read port, and captures the returned words with their PCs. It presents them to decode through a valid/ready handshake. It supports stalls, branch/jump redirects that flush fetched-but-unconsumed instructions, and full one-instruction-per-cycle throughput over the memory's one-cycle read latency.

## Interface
- RESET_PC, 16'h0000: PC loaded on reset (word address).
- ADDR_W, 16: memory word-address width.
- DATA_W, 32: instruction width.
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset.
- run  input  1  fetch enable; 0 stops new requests (outstanding one still completes).
- redirect_valid  input  1  one-cycle redirect/flush request.
- redirect_pc  input  ADDR_W  new PC for redirect.
- mem_rd  output  1  read strobe to instruction memory (rd).
- mem_wn  output  1  write strobe to memory; tied 0.
- mem_address  output  ADDR_W  read address, equals current PC.
- mem_read_data  input  DATA_W  memory read data, valid the cycle after mem_rd.
- instr_valid  output  1  buffer head holds a valid instruction.
- instr_ready  input  1  decode accepts head this cycle.
- instr  output  DATA_W  instruction at buffer head.
- instr_pc  output  ADDR_W  PC of instr.

## Operation
- Clock clk; reset is synchronous and active-low (reset_n), sampled on posedge clk.
- State: pc register, pending flag + pending_pc (request issued last cycle), 2-entry FIFO of {instr, pc}.
- pop = instr_valid & instr_ready & ~redirect_valid.
- count = fifo_occupancy + pending; issue = run & ~redirect_valid & ((count - pop) < 2).
- mem_rd = issue (combinational); mem_address = pc (combinational); mem_wn = 0 always.
- On issue: pc <= pc + 1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000); pending <= 1, pending_pc <= pc. Else pending <= 0.
- If pending and no redirect: push {mem_read_data, pending_pc} into FIFO. The issue rule guarantees no overflow.
- pop removes head; push and pop in the same cycle both take effect.
- Redirect (redirect_valid=1):
  - FIFO cleared.
  - Response arriving this cycle (pending=1) discarded.
  - No issue this cycle.
  - pc <= redirect_pc; pending <= 0.
  - instr_ready is ignored that cycle.
  - Applies regardless of run.
- run=0: pc holds and no new reads are issued; the FIFO still drains and any pending response is still captured.
- Reset values: pc=RESET_PC, pending=0, FIFO empty, instr_valid=0, instr=0, instr_pc=0, mem_rd=0.
- reset_n low mid-operation discards FIFO and in-flight read on that edge; mem_rd forced 0 while reset_n=0.

## Timing
- Request at cycle t (mem_rd=1, address A); data sampled from mem_read_data at end of t+1; instr_valid with instr_pc=A in t+2.
- First fetch: cycle after reset_n rises with run=1, address RESET_PC; first instr_valid two cycles later.
- Sustained throughput 1 instr/cycle with instr_ready held 1.
- Decode stall: at most 2 instructions accumulate (FIFO holds fetched + in-flight); mem_rd drops until pop.
- Redirect in cycle r: first request to redirect_pc at r+1; its instr_valid at r+3. instr_valid is 0 in r+1 and r+2.
- instr/instr_pc stable while instr_valid=1 and instr_ready=0.

## Test plan
- Reset, run=1, ready=1, memory word k = 32'hA000_0000+k: mem_rd high every cycle from cycle 0; instr_pc 0,1,2,… on consecutive cycles from cycle 2; instr = 32'hA000_0000, 32'hA000_0001, …
- instr_ready=0 for 5 cycles mid-stream: exactly 2 buffered; mem_rd low after stall fills; resume yields contiguous PCs with no loss or duplication.
- redirect_valid with redirect_pc=16'h0100 while FIFO holds 2 entries and a read pending: no stale instr appears; next instr_pc=16'h0100 exactly 3 cycles after redirect.
- RESET_PC=16'hFFFE, run=1, ready=1: instr_pc sequence FFFE, FFFF, 0000, 0001.
- run dropped after first issue: the pending instruction still appears; no further mem_rd. run=1 resumes at the next sequential PC.
- reset_n low for 1 cycle with full FIFO and a read pending: instr_valid=0 next cycle; refetch starts at RESET_PC; mem_wn never 1 throughout.
